// File: rtl/rv32_wb_pkg.sv
// Shared types for the RV32 writeback stage: load width encoding and FSM states.
package rv32_wb_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_width_t;

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } wb_state_t;

endpackage

// File: rtl/rv32_load_align.sv
// Combinational load aligner: selects the byte/half lane from the data-bus word and extends it.
module rv32_load_align
  import rv32_wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  width,
  input  logic        zero_ext,
  input  logic [1:0]  addr_lo,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        sgn_b;
  logic        sgn_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    sgn_b  = ~zero_ext & lane_b[7];
    sgn_h  = ~zero_ext & lane_h[15];
    case (width)
      MEM_B:   value = {{24{sgn_b}}, lane_b};
      MEM_H:   value = {{16{sgn_h}}, lane_h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/rv32_writeback.sv
// RV32 writeback stage: registers memory-stage results, waits for load data, drives the regfile
// write port. Optional retired-instruction counter enabled by RV32_WB_INSTRET_EN.
module rv32_writeback
  import rv32_wb_pkg::*;
`ifdef RV32_WB_INSTRET_EN
#(
  parameter int INSTRET_WIDTH = 64
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        flush_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic        mem_read_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_ext_in,
  input  logic [1:0]  mem_addr_lo_in,
  input  logic [31:0] dbus_rdata_in,
  input  logic        dbus_ready_in,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out,
  output logic        writeback_flush_out
`ifdef RV32_WB_INSTRET_EN
  ,
  output logic [INSTRET_WIDTH-1:0] instret_out
`endif
);

  wb_state_t   state;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_width;
  logic        ld_zext;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_value;

  assign ready_out = (state == IDLE);

  // Alignment runs on the latched load attributes so the op's fields need not be held upstream.
  rv32_load_align u_align (
    .rdata    (dbus_rdata_in),
    .width    (ld_width),
    .zero_ext (ld_zext),
    .addr_lo  (ld_addr_lo),
    .value    (ld_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      ld_rd               <= '0;
      ld_width            <= MEM_W;
      ld_zext             <= 1'b0;
      ld_addr_lo          <= '0;
      rd_out              <= '0;
      rd_write_out        <= 1'b0;
      rd_value_out        <= '0;
      writeback_flush_out <= 1'b1;
    end else begin
      // Slot is empty unless something retires this edge; rd/value hold their last contents.
      rd_write_out        <= 1'b0;
      writeback_flush_out <= 1'b1;
      case (state)
        IDLE: begin
          if (valid_in && !flush_in) begin
            if (mem_read_in) begin
              ld_rd      <= rd_in;
              ld_width   <= mem_width_in;
              ld_zext    <= mem_zero_ext_in;
              ld_addr_lo <= mem_addr_lo_in;
              state      <= LOAD_WAIT;
            end else begin
              rd_out              <= rd_in;
              rd_value_out        <= result_in;
              rd_write_out        <= rd_write_in && (|rd_in);
              writeback_flush_out <= 1'b0;
            end
          end
        end
        LOAD_WAIT: begin
          if (dbus_ready_in) begin
            rd_out              <= ld_rd;
            rd_value_out        <= ld_value;
            rd_write_out        <= |ld_rd;
            writeback_flush_out <= 1'b0;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RV32_WB_INSTRET_EN
  // Counts every occupied output slot, including rd=0 and non-writing ops; wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      instret_out <= '0;
    else if (!writeback_flush_out)
      instret_out <= instret_out + 1'b1;
  end
`endif

endmodule
